mux32_16x1: RTL and testbench

Word-wide select tree for the datapath: one 32-bit result from up to sixteen 32-bit inputs, plus the 8:1, 4:1 and 2:1 results taken from the same select bus. Leaf 2:1, 4:1 and 8:1 stages are instantiated hierarchically to form the 16:1. The register-file read path and the ALU operand/result selection use it. Combinational outputs serve same-cycle paths; a registered copy of each result serves pipelined consumers.

---
 rtl/mux32_16x1.sv | 178 +++++++++++++++++
 tb/tb_mux32_16x1.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux32_16x1.sv
// mux32_16x1: word-wide 16:1 select tree with 8:1, 4:1 and 2:1 taps.
// Combinational results serve same-cycle consumers; registered copies
// serve pipelined consumers. Only S[3:0] participates in selection.

// Leaf 2:1 word mux, bitwise on a single select bit.
module mux32_2x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             s,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] y
);

  // Pick i1 when s is set, otherwise i0.
  always_comb begin
    y = i0;
    if (s) y = i1;
  end

endmodule

// 4:1 word mux built from two 2:1 stages on s[0] and one on s[1].
// The lower 2:1 result is exported so the top can reuse it as Y2.
module mux32_4x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y2
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  mux32_2x1 #(.WIDTH(WIDTH)) u_lo (.s(s[0]), .i0(i0), .i1(i1), .y(lo));
  mux32_2x1 #(.WIDTH(WIDTH)) u_hi (.s(s[0]), .i0(i2), .i1(i3), .y(hi));
  mux32_2x1 #(.WIDTH(WIDTH)) u_out (.s(s[1]), .i0(lo), .i1(hi), .y(y));

  // Lower pair result doubles as the 2:1 tap.
  always_comb begin
    y2 = lo;
  end

endmodule

// 8:1 word mux built from two 4:1 stages on s[1:0] and a 2:1 on s[2].
// The lower half's 4:1 and 2:1 results are exported as taps.
module mux32_8x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y2
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo2;
  logic [WIDTH-1:0] hi2_unused;

  mux32_4x1 #(.WIDTH(WIDTH)) u_lo (
    .s(s[1:0]), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .y(lo), .y2(lo2)
  );
  mux32_4x1 #(.WIDTH(WIDTH)) u_hi (
    .s(s[1:0]), .i0(i4), .i1(i5), .i2(i6), .i3(i7), .y(hi), .y2(hi2_unused)
  );
  mux32_2x1 #(.WIDTH(WIDTH)) u_out (.s(s[2]), .i0(lo), .i1(hi), .y(y));

  // Lower half results double as the 4:1 and 2:1 taps.
  always_comb begin
    y4 = lo;
    y2 = lo2;
  end

endmodule

// Top: 16:1 from two 8:1 stages on S[2:0] and a 2:1 on S[3],
// with the narrower results taken from the lower 8:1 stage.
module mux32_16x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      S,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic [WIDTH-1:0] I8,
  input  logic [WIDTH-1:0] I9,
  input  logic [WIDTH-1:0] I10,
  input  logic [WIDTH-1:0] I11,
  input  logic [WIDTH-1:0] I12,
  input  logic [WIDTH-1:0] I13,
  input  logic [WIDTH-1:0] I14,
  input  logic [WIDTH-1:0] I15,
  output logic [WIDTH-1:0] Y16,
  output logic [WIDTH-1:0] Y8,
  output logic [WIDTH-1:0] Y4,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y16_R,
  output logic [WIDTH-1:0] Y8_R,
  output logic [WIDTH-1:0] Y4_R,
  output logic [WIDTH-1:0] Y2_R
);

  logic [3:0]       sel;
  logic             sel_unused;
  logic [WIDTH-1:0] lo8;
  logic [WIDTH-1:0] hi8;
  logic [WIDTH-1:0] lo4;
  logic [WIDTH-1:0] lo2;
  logic [WIDTH-1:0] hi4_unused;
  logic [WIDTH-1:0] hi2_unused;

  // Only the low nibble of the select bus steers the tree.
  always_comb begin
    sel        = S[3:0];
    sel_unused = ^S[31:4];
  end

  mux32_8x1 #(.WIDTH(WIDTH)) u_lo (
    .s(sel[2:0]),
    .i0(I0), .i1(I1), .i2(I2), .i3(I3),
    .i4(I4), .i5(I5), .i6(I6), .i7(I7),
    .y(lo8), .y4(lo4), .y2(lo2)
  );

  mux32_8x1 #(.WIDTH(WIDTH)) u_hi (
    .s(sel[2:0]),
    .i0(I8),  .i1(I9),  .i2(I10), .i3(I11),
    .i4(I12), .i5(I13), .i6(I14), .i7(I15),
    .y(hi8), .y4(hi4_unused), .y2(hi2_unused)
  );

  mux32_2x1 #(.WIDTH(WIDTH)) u_out (.s(sel[3]), .i0(lo8), .i1(hi8), .y(Y16));

  // Narrower results come straight from the lower 8:1 stage.
  always_comb begin
    Y8 = lo8;
    Y4 = lo4;
    Y2 = lo2;
  end

  // Registered copies; asynchronous reset overrides any clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Y16_R <= '0;
      Y8_R  <= '0;
      Y4_R  <= '0;
      Y2_R  <= '0;
    end else begin
      Y16_R <= Y16;
      Y8_R  <= Y8;
      Y4_R  <= Y4;
      Y2_R  <= Y2;
    end
  end

endmodule

// File: tb/tb_mux32_16x1.sv
// Self-checking bench for mux32_16x1 against an array-indexing reference.
module tb_mux32_16x1;

  logic        clk;
  logic        rst;
  logic [31:0] s;
  logic [31:0] din [16];
  logic [31:0] y16, y8, y4, y2, y16_r, y8_r, y4_r, y2_r;

  int checks = 0;
  int errors = 0;

  mux32_16x1 #(.WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .S(s),
    .I0(din[0]),   .I1(din[1]),   .I2(din[2]),   .I3(din[3]),
    .I4(din[4]),   .I5(din[5]),   .I6(din[6]),   .I7(din[7]),
    .I8(din[8]),   .I9(din[9]),   .I10(din[10]), .I11(din[11]),
    .I12(din[12]), .I13(din[13]), .I14(din[14]), .I15(din[15]),
    .Y16(y16), .Y8(y8), .Y4(y4), .Y2(y2),
    .Y16_R(y16_r), .Y8_R(y8_r), .Y4_R(y4_r), .Y2_R(y2_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick input at index (select mod n).
  function automatic logic [31:0] ref_sel(input logic [31:0] sv, input int n);
    return din[sv % n];
  endfunction

  task automatic set_index_inputs();
    for (int k = 0; k < 16; k++) din[k] = k;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s = '0;
    set_index_inputs();
    #2;
    checks++;
    if ({y16_r, y8_r, y4_r, y2_r} !== 128'd0) begin
      errors++;
      $display("FAIL reset_regs got %h %h %h %h want 0", y16_r, y8_r, y4_r, y2_r);
    end
    @(posedge clk); #1;
    checks++;
    if (y16_r !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold got %h want 0", y16_r);
    end
  endtask

  task automatic test_comb_sweep();
    set_index_inputs();
    for (int v = 0; v < 16; v++) begin
      s = v;
      #10;
      checks++;
      if (y16 !== v || y8 !== (v % 8) || y4 !== (v % 4) || y2 !== (v % 2)) begin
        errors++;
        $display("FAIL sweep s=%0d got %0d %0d %0d %0d want %0d %0d %0d %0d",
                 v, y16, y8, y4, y2, v, v % 8, v % 4, v % 2);
      end
    end
  endtask

  task automatic test_upper_bits();
    logic [31:0] sels [3];
    logic [31:0] e16, e8, e4, e2;
    sels[0] = 32'hFFFF_FFF0;
    sels[1] = 32'h0000_0013;
    sels[2] = 32'h0000_0010;
    set_index_inputs();
    for (int j = 0; j < 3; j++) begin
      s = sels[j];
      #1;
      e16 = (sels[j] & 32'hF);
      e8  = (sels[j] & 32'h7);
      e4  = (sels[j] & 32'h3);
      e2  = (sels[j] & 32'h1);
      checks++;
      if (y16 !== e16 || y8 !== e8 || y4 !== e4 || y2 !== e2) begin
        errors++;
        $display("FAIL upper_bits s=%h got %0d %0d %0d %0d want %0d %0d %0d %0d",
                 sels[j], y16, y8, y4, y2, e16, e8, e4, e2);
      end
    end
  endtask

  task automatic test_pattern();
    logic [31:0] want;
    din[0] = 32'hAAAA_5555;
    din[1] = 32'h5555_AAAA;
    for (int t = 0; t < 4; t++) begin
      s = t % 2;
      #1;
      want = (t % 2 == 1) ? 32'h5555_AAAA : 32'hAAAA_5555;
      checks++;
      if (y2 !== want || y4 !== want || y8 !== want || y16 !== want) begin
        errors++;
        $display("FAIL pattern s=%0d got %h %h %h %h want %h", s, y2, y4, y8, y16, want);
      end
    end
  endtask

  task automatic test_registered();
    set_index_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    s = 7;
    @(posedge clk); #1;
    checks++;
    if (y16_r !== 32'd7 || y8_r !== 32'd7 || y4_r !== 32'd3 || y2_r !== 32'd1) begin
      errors++;
      $display("FAIL reg_load7 got %0d %0d %0d %0d want 7 7 3 1", y16_r, y8_r, y4_r, y2_r);
    end
    s = 12;
    #1;
    checks++;
    if (y16 !== 32'd12 || y16_r !== 32'd7) begin
      errors++;
      $display("FAIL reg_latency got y16=%0d y16_r=%0d want 12 7", y16, y16_r);
    end
    @(posedge clk); #1;
    checks++;
    if (y16_r !== 32'd12 || y8_r !== 32'd4 || y4_r !== 32'd0 || y2_r !== 32'd0) begin
      errors++;
      $display("FAIL reg_load12 got %0d %0d %0d %0d want 12 4 0 0", y16_r, y8_r, y4_r, y2_r);
    end
  endtask

  task automatic test_reset_async();
    // Called 1 ns after an edge with Y16_R = 12.
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({y16_r, y8_r, y4_r, y2_r} !== 128'd0) begin
      errors++;
      $display("FAIL async_clear got %h %h %h %h want 0", y16_r, y8_r, y4_r, y2_r);
    end
    #2 rst = 1'b0;
    #2;
    checks++;
    if (y16_r !== 32'd0) begin
      errors++;
      $display("FAIL clear_until_edge got %0d want 0", y16_r);
    end
    @(posedge clk); #1;
    checks++;
    if (y16_r !== 32'd12) begin
      errors++;
      $display("FAIL reload_after_rst got %0d want 12", y16_r);
    end
  endtask

  task automatic test_reset_held();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 16; k++) din[k] = $urandom;
      s = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({y16_r, y8_r, y4_r, y2_r} !== 128'd0) begin
        errors++;
        $display("FAIL held_regs cyc=%0d got %h want 0", c, y16_r);
      end
      checks++;
      if (y16 !== ref_sel(s, 16) || y8 !== ref_sel(s, 8) ||
          y4 !== ref_sel(s, 4) || y2 !== ref_sel(s, 2)) begin
        errors++;
        $display("FAIL held_comb s=%h got %h want %h", s, y16, ref_sel(s, 16));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] p16, p8, p4, p2;
    for (int k = 0; k < 16; k++) din[k] = $urandom;
    s = $urandom;
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      p16 = ref_sel(s, 16); p8 = ref_sel(s, 8);
      p4  = ref_sel(s, 4);  p2 = ref_sel(s, 2);
      checks++;
      if (y16 !== p16 || y8 !== p8 || y4 !== p4 || y2 !== p2) begin
        errors++;
        $display("FAIL rand_comb s=%h got %h %h %h %h want %h %h %h %h",
                 s, y16, y8, y4, y2, p16, p8, p4, p2);
      end
      @(posedge clk); #1;
      checks++;
      if (y16_r !== p16 || y8_r !== p8 || y4_r !== p4 || y2_r !== p2) begin
        errors++;
        $display("FAIL rand_reg got %h %h %h %h want %h %h %h %h",
                 y16_r, y8_r, y4_r, y2_r, p16, p8, p4, p2);
      end
      for (int k = 0; k < 16; k++) din[k] = $urandom;
      s = $urandom;
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    test_upper_bits();
    test_pattern();
    test_registered();
    test_reset_async();
    test_reset_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
